// File: rtl/fp32_mul_result_buffer.sv
// Result buffer behind the non-stallable FP32 multiplier: captures products on done_i,
// serves them with valid/ready, and grants issue credits so the buffer cannot overflow.
module fp32_mul_result_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_i,
   output logic             issue_ready_o,
   input  logic             done_i,
   input  logic [31:0]      result_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_data_o,
   output logic             out_zero_o,
   output logic             out_special_o,
   output logic [CNT_W-1:0] count_o,
   output logic             overflow_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned DATA_W = 32;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic              mem_zero [DEPTH];
   logic              mem_special [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  outstanding;

   logic full;
   logic pop;
   logic push;
   logic drop;
   logic issue_acc;
   logic in_zero;
   logic in_special;

   // Handshake decode; a push into a full buffer only lands if a pop frees a slot.
   always_comb begin
      full       = (count_o == CNT_W'(DEPTH));
      pop        = out_valid_o & out_ready_i;
      push       = done_i & (~full | pop);
      drop       = done_i & full & ~pop;
      issue_acc  = issue_i & issue_ready_o;
      in_zero    = (result_i[30:23] == 8'h00) && (result_i[22:0] == 23'h0);
      in_special = (result_i[30:23] == 8'hFF);
   end

   assign out_valid_o   = (count_o != '0);
   assign issue_ready_o = (outstanding < CNT_W'(DEPTH));
   assign out_data_o    = mem_data[rd_ptr];
   assign out_zero_o    = mem_zero[rd_ptr];
   assign out_special_o = mem_special[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_o    <= '0;
         overflow_o <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data[i]    <= '0;
            mem_zero[i]    <= 1'b0;
            mem_special[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_data[wr_ptr]    <= result_i;
            mem_zero[wr_ptr]    <= in_zero;
            mem_special[wr_ptr] <= in_special;
            wr_ptr              <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count_o <= count_o + CNT_W'(1);
         end else if (pop && !push) begin
            count_o <= count_o - CNT_W'(1);
         end
         if (drop) begin
            overflow_o <= 1'b1;
         end
      end
   end

   // Credits: reserved at issue, returned when the consumer takes the entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else if (issue_acc && !pop) begin
         outstanding <= outstanding + CNT_W'(1);
      end else if (pop && !issue_acc && (outstanding != '0)) begin
         // Guard keeps the count sane if products arrive without a matching issue.
         outstanding <= outstanding - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fp32_mul_result_buffer.sv
// Directed self-checking bench for fp32_mul_result_buffer with hand-computed expectations.
module tb_fp32_mul_result_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             issue_i;
   logic             issue_ready_o;
   logic             done_i;
   logic [31:0]      result_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [31:0]      out_data_o;
   logic             out_zero_o;
   logic             out_special_o;
   logic [CNT_W-1:0] count_o;
   logic             overflow_o;

   int total = 0;
   int bad   = 0;

   fp32_mul_result_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .issue_i      (issue_i),
      .issue_ready_o(issue_ready_o),
      .done_i       (done_i),
      .result_i     (result_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_zero_o   (out_zero_o),
      .out_special_o(out_special_o),
      .count_o      (count_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] v);
      done_i   = 1'b1;
      result_i = v;
      tick();
      done_i   = 1'b0;
      result_i = '0;
   endtask

   task automatic pop_one();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
   endtask

   int accepted;

   initial begin
      rst_i       = 1'b1;
      issue_i     = 1'b0;
      done_i      = 1'b0;
      result_i    = '0;
      out_ready_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      tick();

      // 1. reset, idle
      check_val("rst_valid", 32'(out_valid_o), 32'd0);
      check_val("rst_iready", 32'(issue_ready_o), 32'd1);
      check_val("rst_count", 32'(count_o), 32'd0);
      check_val("rst_ovf", 32'(overflow_o), 32'd0);
      check_val("rst_data", out_data_o, 32'h0);

      // 2. single product, 7 cycles after issue
      issue_i = 1'b1;
      tick();
      issue_i = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check_val("single_pre_valid", 32'(out_valid_o), 32'd0);
      push_one(32'h40C00000);
      check_val("single_valid", 32'(out_valid_o), 32'd1);
      check_val("single_data", out_data_o, 32'h40C00000);
      check_val("single_zero", 32'(out_zero_o), 32'd0);
      check_val("single_special", 32'(out_special_o), 32'd0);
      check_val("single_count", 32'(count_o), 32'd1);
      pop_one();
      check_val("single_pop_count", 32'(count_o), 32'd0);
      check_val("single_pop_valid", 32'(out_valid_o), 32'd0);
      check_val("single_pop_iready", 32'(issue_ready_o), 32'd1);

      // 3. credit throttle
      accepted = 0;
      issue_i  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (issue_ready_o) accepted++;
         tick();
      end
      issue_i = 1'b0;
      check_val("thr_accepted", 32'(accepted), 32'd8);
      check_val("thr_iready_low", 32'(issue_ready_o), 32'd0);
      for (int i = 0; i < 8; i++) push_one(32'h3F800000 + 32'(i));
      check_val("thr_count", 32'(count_o), 32'd8);
      check_val("thr_ovf", 32'(overflow_o), 32'd0);
      check_val("thr_head", out_data_o, 32'h3F800000);
      check_val("thr_iready_full", 32'(issue_ready_o), 32'd0);
      pop_one();
      check_val("thr_pop_iready", 32'(issue_ready_o), 32'd1);
      check_val("thr_pop_count", 32'(count_o), 32'd7);
      check_val("thr_pop_head", out_data_o, 32'h3F800001);

      // 4. full with simultaneous push and pop
      issue_i = 1'b1;
      tick();
      issue_i = 1'b0;
      check_val("full_iready", 32'(issue_ready_o), 32'd0);
      push_one(32'h3F800008);
      check_val("full_count", 32'(count_o), 32'd8);
      out_ready_i = 1'b1;
      done_i      = 1'b1;
      result_i    = 32'h3F800009;
      tick();
      out_ready_i = 1'b0;
      done_i      = 1'b0;
      check_val("pp_count", 32'(count_o), 32'd8);
      check_val("pp_ovf", 32'(overflow_o), 32'd0);
      check_val("pp_head", out_data_o, 32'h3F800002);

      // 5. forced overflow, issuer bypassed
      push_one(32'hDEADBEEF);
      check_val("ovf_set", 32'(overflow_o), 32'd1);
      check_val("ovf_count", 32'(count_o), 32'd8);
      check_val("ovf_head", out_data_o, 32'h3F800002);
      tick();
      check_val("ovf_sticky", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("drain_%0d", i), out_data_o, 32'h3F800002 + 32'(i));
         pop_one();
      end
      check_val("drain_count", 32'(count_o), 32'd0);
      check_val("drain_valid", 32'(out_valid_o), 32'd0);
      check_val("drain_ovf", 32'(overflow_o), 32'd1);

      // 6. flags, then reset mid-stream
      push_one(32'h80000000);
      push_one(32'h7F800000);
      check_val("flag0_data", out_data_o, 32'h80000000);
      check_val("flag0_zero", 32'(out_zero_o), 32'd1);
      check_val("flag0_special", 32'(out_special_o), 32'd0);
      pop_one();
      check_val("flag1_data", out_data_o, 32'h7F800000);
      check_val("flag1_zero", 32'(out_zero_o), 32'd0);
      check_val("flag1_special", 32'(out_special_o), 32'd1);
      push_one(32'h3F800000);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_val("mrst_count", 32'(count_o), 32'd0);
      check_val("mrst_valid", 32'(out_valid_o), 32'd0);
      check_val("mrst_ovf", 32'(overflow_o), 32'd0);
      check_val("mrst_iready", 32'(issue_ready_o), 32'd1);
      check_val("mrst_data", out_data_o, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
